// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: datapath width, result-slot state encodings
// and the round-robin pick used to choose between the two requesters.
package adder_arbiter_pkg;

  localparam int unsigned WORD = 64;

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  // Index of the requester to grant; only meaningful when at least one is valid.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last_grant);
    if (v0 && v1) begin
      return ~last_grant;
    end
    return v1;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational WORD-bit adder; the carry out is dropped.
module adder #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder through a round-robin arbiter feeding a single
// registered result slot with valid/ready backpressure and one-per-cycle throughput.
module adder_arbiter
  import adder_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid_in,
  input  logic [WORD-1:0] req0_a_in,
  input  logic [WORD-1:0] req0_b_in,
  output logic            req0_ready_out,
  input  logic            req1_valid_in,
  input  logic [WORD-1:0] req1_a_in,
  input  logic [WORD-1:0] req1_b_in,
  output logic            req1_ready_out,
  output logic            res_valid_out,
  output logic [WORD-1:0] res_data_out,
  output logic            res_id_out,
  input  logic            res_ready_in
);

  logic            state_q, state_d;
  logic [WORD-1:0] data_q, data_d;
  logic            id_q, id_d;
  logic            last_grant_q, last_grant_d;
  logic            slot_free;
  logic            grant, grant_idx;
  logic [WORD-1:0] op_a, op_b, sum;

  assign slot_free = (state_q == EMPTY) || res_ready_in;

  // Grants are suppressed while reset is held so nothing is accepted in the reset cycle.
  always_comb begin
    grant     = 1'b0;
    grant_idx = 1'b0;
    if (!reset && slot_free && (req0_valid_in || req1_valid_in)) begin
      grant     = 1'b1;
      grant_idx = rr_pick(req0_valid_in, req1_valid_in, last_grant_q);
    end
  end

  assign req0_ready_out = grant && !grant_idx;
  assign req1_ready_out = grant && grant_idx;

  assign op_a = grant_idx ? req1_a_in : req0_a_in;
  assign op_b = grant_idx ? req1_b_in : req0_b_in;

  adder #(
    .Width(WORD)
  ) u_adder (
    .a  (op_a),
    .b  (op_b),
    .sum(sum)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      data_d       = sum;
      id_d         = grant_idx;
      last_grant_d = grant_idx;
    end
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (res_ready_in && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid_out = (state_q == FULL);
  assign res_data_out  = data_q;
  assign res_id_out    = id_q;

endmodule
